// File: rtl/reg_scoreboard_if.sv
// Decode-to-scoreboard bundle: source reads, destination write, and stall/issue replies.
// The master modport is the decode stage; the slave modport is the scoreboard.
interface reg_scoreboard_if #(
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5,
   parameter int NUM_READ  = 2,
   parameter int LAT_W     = 2
);
   logic                         id_valid;
   logic                         hold;
   logic                         flush;
   logic [NUM_READ-1:0]          rd_en;
   logic [NUM_READ*ADDR_W-1:0]   rd_addr;
   logic                         wr_en;
   logic [ADDR_W-1:0]            wr_addr;
   logic [LAT_W-1:0]             wr_lat;
   logic                         stall;
   logic                         issue;
   logic [REG_COUNT-1:0]         busy_mask;

   // Handshake: an instruction held on id_valid is accepted in the cycle issue=1;
   // while stall=1 decode keeps the same instruction and its fields stable.
   modport master (
      output id_valid, hold, flush, rd_en, rd_addr, wr_en, wr_addr, wr_lat,
      input  stall, issue, busy_mask
   );

   modport slave (
      input  id_valid, hold, flush, rd_en, rd_addr, wr_en, wr_addr, wr_lat,
      output stall, issue, busy_mask
   );
endinterface

// File: rtl/reg_scoreboard.sv
// GPR scoreboard: per-register pending-latency counters giving RAW/WAW decode stalls.
// Define REG_SCOREBOARD_STATS_EN to add the saturating stall_cycles counter output.
module reg_scoreboard #(
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5,
   parameter int NUM_READ  = 2,
   parameter int LAT_W     = 2
) (
   input  logic               clk,
   input  logic               rst,
`ifdef REG_SCOREBOARD_STATS_EN
   output logic [31:0]        stall_cycles,
`endif
   reg_scoreboard_if.slave    sb
);

   logic [LAT_W-1:0] cnt [REG_COUNT];
   logic             raw_hit;
   logic             waw_hit;
   logic             issue_w;
   logic             stall_w;

   always_comb begin
      raw_hit = 1'b0;
      for (int i = 0; i < NUM_READ; i++) begin
         if (sb.rd_en[i] && (sb.rd_addr[i*ADDR_W +: ADDR_W] != '0) &&
             (cnt[sb.rd_addr[i*ADDR_W +: ADDR_W]] != '0))
            raw_hit = 1'b1;
      end
   end

   // A younger writer may issue once the older one finishes no later than it does.
   assign waw_hit = sb.wr_en && (sb.wr_addr != '0) && (cnt[sb.wr_addr] > sb.wr_lat);

   assign stall_w = sb.id_valid && !sb.flush && (raw_hit || waw_hit || sb.hold);
   assign issue_w = sb.id_valid && !sb.flush && !sb.hold && !raw_hit && !waw_hit;

   assign sb.stall = stall_w;
   assign sb.issue = issue_w;

   always_comb begin
      sb.busy_mask = '0;
      for (int r = 0; r < REG_COUNT; r++)
         sb.busy_mask[r] = (cnt[r] != '0);
   end

   // Register 0 is hardwired zero, so its counter never becomes pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < REG_COUNT; r++)
            cnt[r] <= '0;
      end else if (!sb.hold) begin
         for (int r = 0; r < REG_COUNT; r++) begin
            if (r == 0)
               cnt[r] <= '0;
            else if (issue_w && sb.wr_en && (sb.wr_addr == ADDR_W'(r)))
               cnt[r] <= sb.wr_lat;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
         end
      end
   end

`ifdef REG_SCOREBOARD_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles <= '0;
      else if (stall_w && !sb.hold && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: drivers push expected {stall, issue, busy_mask}
// per cycle; a negedge monitor pops and compares.
module tb_reg_scoreboard;
   localparam int W = 34;

   logic clk;
   logic rst;
   reg_scoreboard_if #(.REG_COUNT(32), .ADDR_W(5), .NUM_READ(2), .LAT_W(2)) sb_if ();

`ifdef REG_SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] stat_q[$];
   logic [31:0] model_stalls;
   logic [31:0] m_stat;
`endif

   reg_scoreboard #(.REG_COUNT(32), .ADDR_W(5), .NUM_READ(2), .LAT_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef REG_SCOREBOARD_STATS_EN
      .stall_cycles (stall_cycles),
`endif
      .sb           (sb_if)
   );

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks;
   int           errors;
   logic [W-1:0] m_exp;
   logic [W-1:0] m_act;
   string        m_name;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      rst             = 1'b0;
      sb_if.id_valid  = 1'b0;
      sb_if.hold      = 1'b0;
      sb_if.flush     = 1'b0;
      sb_if.rd_en     = '0;
      sb_if.rd_addr   = '0;
      sb_if.wr_en     = 1'b0;
      sb_if.wr_addr   = '0;
      sb_if.wr_lat    = '0;
      checks          = 0;
      errors          = 0;
`ifdef REG_SCOREBOARD_STATS_EN
      model_stalls    = '0;
`endif
   end

   // driver: one call = one cycle of decode inputs plus the expected response
   task automatic cyc(input logic rs, input logic iv, input logic hd, input logic fl,
                      input logic [1:0] re, input int a0, input int a1,
                      input logic we, input int wa, input int wl,
                      input logic es, input logic ei, input logic [31:0] eb,
                      input string nm);
      @(posedge clk);
      #1;
      rst            = rs;
      sb_if.id_valid = iv;
      sb_if.hold     = hd;
      sb_if.flush    = fl;
      sb_if.rd_en    = re;
      sb_if.rd_addr  = {5'(a1), 5'(a0)};
      sb_if.wr_en    = we;
      sb_if.wr_addr  = 5'(wa);
      sb_if.wr_lat   = 2'(wl);
      exp_q.push_back({es, ei, eb});
      name_q.push_back(nm);
`ifdef REG_SCOREBOARD_STATS_EN
      if (!rs) model_stalls = '0;
      stat_q.push_back(model_stalls);
      if (es && !hd && model_stalls != 32'hFFFF_FFFF) model_stalls = model_stalls + 1;
`endif
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         m_exp  = exp_q.pop_front();
         m_name = name_q.pop_front();
         m_act  = {sb_if.stall, sb_if.issue, sb_if.busy_mask};
         checks = checks + 1;
         if (m_act !== m_exp) begin
            errors = errors + 1;
            $display("FAIL %s: got stall=%b issue=%b busy=%h, expected stall=%b issue=%b busy=%h",
                     m_name, m_act[33], m_act[32], m_act[31:0], m_exp[33], m_exp[32], m_exp[31:0]);
         end
`ifdef REG_SCOREBOARD_STATS_EN
         m_stat = stat_q.pop_front();
         checks = checks + 1;
         if (stall_cycles !== m_stat) begin
            errors = errors + 1;
            $display("FAIL %s stall_cycles: got %0d, expected %0d", m_name, stall_cycles, m_stat);
         end
`endif
      end
   end

   initial begin
      #200000;
      errors = errors + 1;
      $display("FAIL watchdog: run did not complete within time limit");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   // stimulus: rs iv hd fl re a0 a1 we wa wl | stall issue busy
   initial begin
      cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, "reset_idle");
      // write $3 lat 2, then RAW stall while cnt is 2 and 1
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 3, 2, 0, 1, 32'h0,   "wr3_issue");
      cyc(1, 1, 0, 0, 2'b01, 3, 0, 0, 0, 0, 1, 0, 32'h8,   "rd3_cnt2");
      cyc(1, 1, 0, 0, 2'b01, 3, 0, 0, 0, 0, 1, 0, 32'h8,   "rd3_cnt1");
      cyc(1, 1, 0, 0, 2'b01, 3, 0, 0, 0, 0, 0, 1, 32'h0,   "rd3_free");
      // $0 is never tracked
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 0, 3, 0, 1, 32'h0,   "wr0_issue");
      cyc(1, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 32'h0,   "rd0_port1");
      // hold freezes cnt[5]=1 for three cycles
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 5, 1, 0, 1, 32'h0,   "wr5_issue");
      cyc(1, 1, 1, 0, 2'b01, 5, 0, 0, 0, 0, 1, 0, 32'h20,  "hold_1");
      cyc(1, 1, 1, 0, 2'b01, 5, 0, 0, 0, 0, 1, 0, 32'h20,  "hold_2");
      cyc(1, 1, 1, 0, 2'b01, 5, 0, 0, 0, 0, 1, 0, 32'h20,  "hold_3");
      cyc(1, 1, 0, 0, 2'b01, 5, 0, 0, 0, 0, 1, 0, 32'h20,  "hold_drop");
      cyc(1, 1, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0, 1, 32'h0,   "rd5_free");
      // WAW: cnt[7]=3, new writer lat 1 waits until cnt[7]<=1
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 7, 3, 0, 1, 32'h0,   "wr7_lat3");
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 7, 1, 1, 0, 32'h80,  "waw_cnt3");
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 7, 1, 1, 0, 32'h80,  "waw_cnt2");
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 7, 1, 0, 1, 32'h80,  "waw_cnt1_issue");
      cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h80,  "wr7_loaded1");
      cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,   "wr7_done");
      // flush kills the instruction but counters keep draining
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 9, 3, 0, 1, 32'h0,   "wr9_lat3");
      cyc(1, 1, 0, 1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 32'h200, "flush_raw_a");
      cyc(1, 1, 0, 1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 32'h200, "flush_raw_b");
      cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h200, "cnt9_last");
      cyc(1, 1, 0, 0, 2'b01, 9, 0, 0, 0, 0, 0, 1, 32'h0,   "rd9_free");
      cyc(1, 1, 0, 1, 2'b00, 0, 0, 1, 10, 3, 0, 0, 32'h0,  "flush_wr10");
      cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,   "no_load_wr10");
      // disabled port never stalls, enabled port 1 does
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 4, 3, 0, 1, 32'h0,   "wr4_lat3");
      cyc(1, 1, 0, 0, 2'b00, 4, 4, 0, 0, 0, 0, 1, 32'h10,  "rd4_disabled");
      cyc(1, 1, 0, 0, 2'b10, 0, 4, 0, 0, 0, 1, 0, 32'h10,  "rd4_port1");
      // lat 0 writer
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 4, 0, 1, 0, 32'h10,  "wr4_lat0_waw");
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 4, 0, 0, 1, 32'h0,   "wr4_lat0_issue");
      cyc(1, 1, 0, 0, 2'b01, 4, 0, 0, 0, 0, 0, 1, 32'h0,   "rd4_after_lat0");
      // fill several counters, then reset mid-flight
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 5, 3, 0, 1, 32'h0,   "fill_wr5");
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 6, 3, 0, 1, 32'h20,  "fill_wr6");
      cyc(1, 1, 0, 0, 2'b00, 0, 0, 1, 7, 3, 0, 1, 32'h60,  "fill_wr7");
      cyc(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'he0,  "busy_e0");
      cyc(0, 1, 0, 0, 2'b01, 7, 0, 0, 0, 0, 0, 1, 32'h0,   "async_reset");
      cyc(1, 1, 0, 0, 2'b01, 7, 0, 0, 0, 0, 0, 1, 32'h0,   "post_reset_rd7");
      cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0,   "final_idle");
      repeat (3) @(posedge clk);
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
